// File: rtl/tilelink_ul_1m_3s.sv
// tilelink_ul_1m_3s: TileLink-UL subsystem with one request-injecting master,
// a source-routed 1-to-3 crossbar, three memory-backed slaves and an error
// responder for sources >= 3.
// Optional build macro: TL_UL_ADDR_CHECK_EN. When it is defined, any address bit
// set above the memory index range is answered with d_error. When it is undefined,
// the upper address bits are ignored and the access wraps into memory.

// One crossbar target: a memory-backed slave, or the error responder when IS_ERR is set.
// A request is latched on the handshake edge. The response is produced on the next edge.
module tilelink_ul_1m_3s_slave #(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH/8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_SIZE_WIDTH   = 8,
    parameter int MEM_WORDS       = 16,
    parameter bit IS_ERR          = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req,
    input  logic                       i_d_ready,
    input  logic [TL_OPCODE_WIDTH-1:0] i_opcode,
    input  logic [TL_ADDR_WIDTH-1:0]   i_address,
    input  logic [TL_SIZE_WIDTH-1:0]   i_size,
    input  logic [TL_STRB_WIDTH-1:0]   i_mask,
    input  logic [TL_DATA_WIDTH-1:0]   i_data,
    input  logic [TL_SOURCE_WIDTH-1:0] i_source,
    output logic                       o_busy,
    output logic                       o_d_valid,
    output logic [TL_OPCODE_WIDTH-1:0] o_d_opcode,
    output logic [TL_SIZE_WIDTH-1:0]   o_d_size,
    output logic [TL_DATA_WIDTH-1:0]   o_d_data,
    output logic [TL_SOURCE_WIDTH-1:0] o_d_source,
    output logic                       o_d_error
);
    localparam int OFF = $clog2(TL_STRB_WIDTH);
    localparam int IW  = $clog2(MEM_WORDS);

    logic                       r_req;
    logic [TL_OPCODE_WIDTH-1:0] r_op;
    logic [TL_ADDR_WIDTH-1:0]   r_addr;
    logic [TL_SIZE_WIDTH-1:0]   r_size;
    logic [TL_STRB_WIDTH-1:0]   r_mask;
    logic [TL_DATA_WIDTH-1:0]   r_data;
    logic [TL_SOURCE_WIDTH-1:0] r_src;

    logic                       w_is_put, w_is_get, w_bad_addr, w_err, w_wr;
    logic [IW-1:0]              w_idx;
    logic [TL_DATA_WIDTH-1:0]   w_rdata;
    logic                       w_unused_lo;

    // Capture the request on the handshake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_op   <= '0;
            r_addr <= '0;
            r_size <= '0;
            r_mask <= '0;
            r_data <= '0;
            r_src  <= '0;
        end else begin
            r_req <= i_req;
            if (i_req) begin
                r_op   <= i_opcode;
                r_addr <= i_address;
                r_size <= i_size;
                r_mask <= i_mask;
                r_data <= i_data;
                r_src  <= i_source;
            end
        end
    end

    assign w_is_put    = (r_op == TL_OPCODE_WIDTH'(0)) || (r_op == TL_OPCODE_WIDTH'(1));
    assign w_is_get    = (r_op == TL_OPCODE_WIDTH'(4));
    assign w_idx       = r_addr[OFF+IW-1:OFF];
    assign w_unused_lo = ^r_addr[OFF-1:0];

`ifdef TL_UL_ADDR_CHECK_EN
    assign w_bad_addr = |r_addr[TL_ADDR_WIDTH-1:OFF+IW];
`else
    logic w_unused_hi;
    assign w_unused_hi = ^r_addr[TL_ADDR_WIDTH-1:OFF+IW];
    assign w_bad_addr  = 1'b0;
`endif

    assign w_err = IS_ERR | ~(w_is_put | w_is_get) | (r_size > TL_SIZE_WIDTH'(OFF)) | w_bad_addr;
    assign w_wr  = r_req & w_is_put & ~w_err;

    generate
        if (IS_ERR) begin : g_nomem
            logic w_unused_nm;
            assign w_unused_nm = ^{w_wr, w_idx, r_mask, r_data};
            assign w_rdata     = '0;
        end else begin : g_mem
            logic [MEM_WORDS-1:0][TL_DATA_WIDTH-1:0] r_mem;
            // Byte-lane write. PutFullData writes every byte, and PutPartialData writes only the masked bytes.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem <= '0;
                end else if (w_wr) begin
                    for (int b = 0; b < TL_STRB_WIDTH; b++)
                        if ((r_op == TL_OPCODE_WIDTH'(0)) || r_mask[b])
                            r_mem[w_idx][b*8 +: 8] <= r_data[b*8 +: 8];
                end
            end
            assign w_rdata = r_mem[w_idx];
        end
    endgenerate

    // Register the response one cycle after acceptance. It is held until the master takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_d_valid  <= 1'b0;
            o_d_opcode <= '0;
            o_d_size   <= '0;
            o_d_data   <= '0;
            o_d_source <= '0;
            o_d_error  <= 1'b0;
        end else if (r_req) begin
            o_d_valid  <= 1'b1;
            o_d_opcode <= w_is_get ? TL_OPCODE_WIDTH'(1) : TL_OPCODE_WIDTH'(0);
            o_d_size   <= r_size;
            o_d_data   <= (w_is_get && !w_err) ? w_rdata : '0;
            o_d_source <= r_src;
            o_d_error  <= w_err;
        end else if (o_d_valid && i_d_ready) begin
            o_d_valid  <= 1'b0;
        end
    end

    assign o_busy = r_req | o_d_valid;
endmodule

module tilelink_ul_1m_3s #(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH/8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8,
    parameter int MEM_WORDS       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid_in,
    input  logic [TL_OPCODE_WIDTH-1:0] a_opcode_in,
    input  logic [TL_PARAM_WIDTH-1:0]  a_param_in,
    input  logic [TL_ADDR_WIDTH-1:0]   a_address_in,
    input  logic [TL_SIZE_WIDTH-1:0]   a_size_in,
    input  logic [TL_STRB_WIDTH-1:0]   a_mask_in,
    input  logic [TL_DATA_WIDTH-1:0]   a_data_in,
    input  logic [TL_SOURCE_WIDTH-1:0] a_source_in,
    output logic                       a_valid_tb,
    output logic [TL_OPCODE_WIDTH-1:0] a_opcode_tb,
    output logic [TL_PARAM_WIDTH-1:0]  a_param_tb,
    output logic [TL_ADDR_WIDTH-1:0]   a_address_tb,
    output logic [TL_SIZE_WIDTH-1:0]   a_size_tb,
    output logic [TL_STRB_WIDTH-1:0]   a_mask_tb,
    output logic [TL_DATA_WIDTH-1:0]   a_data_tb,
    output logic [TL_SOURCE_WIDTH-1:0] a_source_tb,
    output logic                       a_ready_tb,
    output logic                       d_valid_tb,
    output logic [TL_OPCODE_WIDTH-1:0] d_opcode_tb,
    output logic [TL_PARAM_WIDTH-1:0]  d_param_tb,
    output logic [TL_SIZE_WIDTH-1:0]   d_size_tb,
    output logic [TL_DATA_WIDTH-1:0]   d_data_tb,
    output logic [TL_SOURCE_WIDTH-1:0] d_source_tb,
    output logic [TL_SINK_WIDTH-1:0]   d_sink_tb,
    output logic                       d_error_tb,
    output logic                       d_ready_tb
);
    localparam int NT = 4;  // three slaves plus the error responder

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_sel;

    logic [NT-1:0]                      w_busy, w_dv, w_derr;
    logic [NT-1:0][TL_OPCODE_WIDTH-1:0] w_dop;
    logic [NT-1:0][TL_SIZE_WIDTH-1:0]   w_dsize;
    logic [NT-1:0][TL_DATA_WIDTH-1:0]   w_ddata;
    logic [NT-1:0][TL_SOURCE_WIDTH-1:0] w_dsrc;

    // Master: latch one request, present it until accepted, then wait for its response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            a_opcode_tb  <= '0;
            a_param_tb   <= '0;
            a_address_tb <= '0;
            a_size_tb    <= '0;
            a_mask_tb    <= '0;
            a_data_tb    <= '0;
            a_source_tb  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (a_valid_in) begin
                    a_opcode_tb  <= a_opcode_in;
                    a_param_tb   <= a_param_in;
                    a_address_tb <= a_address_in;
                    a_size_tb    <= a_size_in;
                    a_mask_tb    <= a_mask_in;
                    a_data_tb    <= a_data_in;
                    a_source_tb  <= a_source_in;
                    r_state      <= S_REQ;
                end
                S_REQ:   if (a_valid_tb && a_ready_tb) r_state <= S_RESP;
                S_RESP:  if (d_valid_tb && d_ready_tb) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign a_valid_tb = (r_state == S_REQ);
    assign d_ready_tb = 1'b1;
    assign w_sel      = (a_source_tb < TL_SOURCE_WIDTH'(3)) ? a_source_tb[1:0] : 2'd3;
    // Ready is qualified by valid so that the idle/reset value stays low.
    assign a_ready_tb = a_valid_tb & ~w_busy[w_sel];

    genvar g;
    generate
        for (g = 0; g < NT; g++) begin : g_tgt
            tilelink_ul_1m_3s_slave #(
                .TL_ADDR_WIDTH(TL_ADDR_WIDTH), .TL_DATA_WIDTH(TL_DATA_WIDTH),
                .TL_STRB_WIDTH(TL_STRB_WIDTH), .TL_SOURCE_WIDTH(TL_SOURCE_WIDTH),
                .TL_OPCODE_WIDTH(TL_OPCODE_WIDTH), .TL_SIZE_WIDTH(TL_SIZE_WIDTH),
                .MEM_WORDS(MEM_WORDS), .IS_ERR(g == NT-1)
            ) u_tgt (
                .clk(clk), .rst(rst),
                .i_req(a_valid_tb & a_ready_tb & (w_sel == 2'(g))),
                .i_d_ready(d_ready_tb),
                .i_opcode(a_opcode_tb), .i_address(a_address_tb), .i_size(a_size_tb),
                .i_mask(a_mask_tb), .i_data(a_data_tb), .i_source(a_source_tb),
                .o_busy(w_busy[g]), .o_d_valid(w_dv[g]), .o_d_opcode(w_dop[g]),
                .o_d_size(w_dsize[g]), .o_d_data(w_ddata[g]), .o_d_source(w_dsrc[g]),
                .o_d_error(w_derr[g])
            );
        end
    endgenerate

    // D-channel return mux: only the single responding target drives, all-zero otherwise.
    always_comb begin
        d_valid_tb  = 1'b0;
        d_opcode_tb = '0;
        d_param_tb  = '0;
        d_size_tb   = '0;
        d_data_tb   = '0;
        d_source_tb = '0;
        d_sink_tb   = '0;
        d_error_tb  = 1'b0;
        for (int t = 0; t < NT; t++) begin
            if (w_dv[t]) begin
                d_valid_tb  = 1'b1;
                d_opcode_tb = w_dop[t];
                d_size_tb   = w_dsize[t];
                d_data_tb   = w_ddata[t];
                d_source_tb = w_dsrc[t];
                d_sink_tb   = TL_SINK_WIDTH'(t);
                d_error_tb  = w_derr[t];
            end
        end
    end
endmodule

// File: tb/tb_tilelink_ul_1m_3s.sv
// Scoreboard bench for tilelink_ul_1m_3s: directed requests push expected responses,
// and a negedge monitor pops and compares each D-channel beat.
module tb_tilelink_ul_1m_3s;
    logic        clk, rst, a_valid_in;
    logic [2:0]  a_opcode_in, a_param_in, a_source_in;
    logic [63:0] a_address_in, a_data_in;
    logic [7:0]  a_size_in, a_mask_in;
    logic        a_valid_tb, a_ready_tb, d_valid_tb, d_error_tb, d_ready_tb;
    logic [2:0]  a_opcode_tb, a_param_tb, a_source_tb, d_opcode_tb, d_param_tb, d_source_tb, d_sink_tb;
    logic [63:0] a_address_tb, a_data_tb, d_data_tb;
    logic [7:0]  a_size_tb, a_mask_tb, d_size_tb;

    tilelink_ul_1m_3s dut (
        .clk(clk), .rst(rst), .a_valid_in(a_valid_in), .a_opcode_in(a_opcode_in),
        .a_param_in(a_param_in), .a_address_in(a_address_in), .a_size_in(a_size_in),
        .a_mask_in(a_mask_in), .a_data_in(a_data_in), .a_source_in(a_source_in),
        .a_valid_tb(a_valid_tb), .a_opcode_tb(a_opcode_tb), .a_param_tb(a_param_tb),
        .a_address_tb(a_address_tb), .a_size_tb(a_size_tb), .a_mask_tb(a_mask_tb),
        .a_data_tb(a_data_tb), .a_source_tb(a_source_tb), .a_ready_tb(a_ready_tb),
        .d_valid_tb(d_valid_tb), .d_opcode_tb(d_opcode_tb), .d_param_tb(d_param_tb),
        .d_size_tb(d_size_tb), .d_data_tb(d_data_tb), .d_source_tb(d_source_tb),
        .d_sink_tb(d_sink_tb), .d_error_tb(d_error_tb), .d_ready_tb(d_ready_tb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  src;
        logic [2:0]  sink;
        logic        err;
        logic [63:0] data;
        logic [7:0]  size;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_chk = 0, n_fail = 0, n_dp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every D beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && d_valid_tb === 1'b1) begin
            n_dp++;
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_d_beat: got source %0d expected no response", d_source_tb);
            end else begin
                m_e = q.pop_front();
                chk("d_opcode", 64'(d_opcode_tb), 64'(m_e.op));
                chk("d_source", 64'(d_source_tb), 64'(m_e.src));
                chk("d_sink",   64'(d_sink_tb),   64'(m_e.sink));
                chk("d_error",  64'(d_error_tb),  64'(m_e.err));
                chk("d_data",   d_data_tb,        m_e.data);
                chk("d_size",   64'(d_size_tb),   64'(m_e.size));
                chk("d_param",  64'(d_param_tb),  64'd0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [2:0] src, input logic [63:0] addr,
                         input logic [7:0] size, input logic [7:0] mask, input logic [63:0] data);
        @(negedge clk);
        a_opcode_in = op; a_source_in = src; a_address_in = addr;
        a_size_in = size; a_mask_in = mask; a_data_in = data; a_param_in = 3'd0;
        a_valid_in = 1'b1;
        @(negedge clk);
        a_valid_in = 1'b0;
    endtask

    task automatic expect_rsp(input logic [2:0] src, input logic [7:0] size, input logic [2:0] eop,
                              input logic eerr, input logic [63:0] edata);
        exp_t e;
        e.op = eop; e.src = src; e.sink = (src < 3) ? src : 3'd3;
        e.err = eerr; e.data = edata; e.size = size;
        q.push_back(e);
    endtask

    task automatic wait_rsp(input int base);
        int k = 0;
        while (n_dp == base && k < 20) begin
            @(negedge clk); #1; k++;
        end
        if (n_dp == base) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_timeout: got no response expected one within 20 cycles");
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] op, input logic [2:0] src, input logic [63:0] addr,
                       input logic [7:0] size, input logic [7:0] mask, input logic [63:0] data,
                       input logic [2:0] eop, input logic eerr, input logic [63:0] edata);
        int base;
        expect_rsp(src, size, eop, eerr, edata);
        base = n_dp;
        issue(op, src, addr, size, mask, data);
        wait_rsp(base);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; a_valid_in = 1'b0; a_opcode_in = '0; a_param_in = '0; a_source_in = '0;
        a_address_in = '0; a_size_in = '0; a_mask_in = '0; a_data_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_a_valid", 64'(a_valid_tb), 64'd0);
        chk("rst_a_ready", 64'(a_ready_tb), 64'd0);
        chk("rst_d_valid", 64'(d_valid_tb), 64'd0);
        chk("rst_d_ready", 64'(d_ready_tb), 64'd1);
        chk("rst_a_addr",  a_address_tb,    64'd0);
        chk("rst_d_data",  d_data_tb,       64'd0);
        rst = 1'b0;

        // First PutFull with cycle-exact timing checks.
        expect_rsp(3'd0, 8'd3, 3'd0, 1'b0, 64'd0);
        base = n_dp;
        issue(3'd0, 3'd0, 64'h0, 8'd3, 8'hFF, 64'hDEADBEEF_CAFEBABE);
        chk("t_k_a_valid", 64'(a_valid_tb), 64'd1);
        chk("t_k_a_ready", 64'(a_ready_tb), 64'd1);
        chk("t_k_a_data",  a_data_tb, 64'hDEADBEEF_CAFEBABE);
        @(negedge clk);
        chk("t_k1_a_valid", 64'(a_valid_tb), 64'd0);
        chk("t_k1_d_valid", 64'(d_valid_tb), 64'd0);
        @(negedge clk); #1;
        chk("t_k2_d_valid", 64'(d_valid_tb), 64'd1);
        @(negedge clk);
        chk("t_k3_d_valid", 64'(d_valid_tb), 64'd0);
        chk("t_one_pulse", 64'(n_dp - base), 64'd1);

        // Independent slaves.
        run(3'd0, 3'd1, 64'h0, 8'd3, 8'hFF, 64'h12345678_9ABCDEF0, 3'd0, 1'b0, 64'd0);
        run(3'd0, 3'd2, 64'h0, 8'd3, 8'hFF, 64'hFEEDFACE_BADC0FFE, 3'd0, 1'b0, 64'd0);
        run(3'd4, 3'd0, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'hDEADBEEF_CAFEBABE);
        run(3'd4, 3'd1, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h12345678_9ABCDEF0);
        run(3'd4, 3'd2, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'hFEEDFACE_BADC0FFE);

        // Unwritten word, then partial write of the low four bytes.
        run(3'd4, 3'd1, 64'h8, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'd0);
        run(3'd1, 3'd1, 64'h0, 8'd3, 8'h0F, 64'd0, 3'd0, 1'b0, 64'd0);
        run(3'd4, 3'd1, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h12345678_00000000);

        // Last memory word.
        run(3'd0, 3'd2, 64'h78, 8'd3, 8'hFF, 64'hA5A5A5A5_5A5A5A5A, 3'd0, 1'b0, 64'd0);
        run(3'd4, 3'd2, 64'h78, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'hA5A5A5A5_5A5A5A5A);

        // Error cases: bad source, oversize, bad opcode. None may write.
        run(3'd4, 3'd5, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b1, 64'd0);
        run(3'd0, 3'd6, 64'h0, 8'd3, 8'hFF, 64'h11111111_11111111, 3'd0, 1'b1, 64'd0);
        run(3'd0, 3'd0, 64'h0, 8'd4, 8'hFF, 64'h22222222_22222222, 3'd0, 1'b1, 64'd0);
        run(3'd2, 3'd0, 64'h0, 8'd3, 8'hFF, 64'h33333333_33333333, 3'd0, 1'b1, 64'd0);
        run(3'd4, 3'd0, 64'h0, 8'd4, 8'hFF, 64'd0, 3'd1, 1'b1, 64'd0);
        run(3'd4, 3'd0, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'hDEADBEEF_CAFEBABE);
        run(3'd4, 3'd2, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'hFEEDFACE_BADC0FFE);

        // a_valid_in pulsed while the master waits for D must be ignored.
        expect_rsp(3'd0, 8'd3, 3'd1, 1'b0, 64'hDEADBEEF_CAFEBABE);
        base = n_dp;
        issue(3'd4, 3'd0, 64'h0, 8'd3, 8'hFF, 64'd0);
        @(negedge clk);
        a_opcode_in = 3'd0; a_source_in = 3'd1; a_address_in = 64'h0;
        a_data_in = 64'hFFFFFFFF_FFFFFFFF; a_valid_in = 1'b1;
        @(negedge clk);
        a_valid_in = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("resp_ignore_pulses", 64'(n_dp - base), 64'd1);
        chk("resp_ignore_idle", 64'(a_valid_tb), 64'd0);
        run(3'd4, 3'd1, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h12345678_00000000);

        // Upper address bits: wrap by default, error with the address check enabled.
`ifdef TL_UL_ADDR_CHECK_EN
        run(3'd0, 3'd0, 64'h80, 8'd3, 8'hFF, 64'h11112222_33334444, 3'd0, 1'b1, 64'd0);
        run(3'd4, 3'd0, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'hDEADBEEF_CAFEBABE);
`else
        run(3'd0, 3'd0, 64'h80, 8'd3, 8'hFF, 64'h11112222_33334444, 3'd0, 1'b0, 64'd0);
        run(3'd4, 3'd0, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h11112222_33334444);
`endif

        // Async reset between A handshake and D response.
        base = n_dp;
        issue(3'd0, 3'd1, 64'h0, 8'd3, 8'hFF, 64'hAAAAAAAA_AAAAAAAA);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_a_valid", 64'(a_valid_tb), 64'd0);
        chk("mid_rst_a_ready", 64'(a_ready_tb), 64'd0);
        chk("mid_rst_d_valid", 64'(d_valid_tb), 64'd0);
        chk("mid_rst_d_ready", 64'(d_ready_tb), 64'd1);
        chk("mid_rst_a_data",  a_data_tb, 64'd0);
        chk("mid_rst_a_src",   64'(a_source_tb), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_no_rsp", 64'(n_dp - base), 64'd0);
        run(3'd4, 3'd1, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'd0);
        run(3'd4, 3'd0, 64'h0, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'd0);
        run(3'd4, 3'd2, 64'h78, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, 64'd0);

        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
